// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: FSM states, opcodes, flag bit indices.
// Imported by alu_core and alu_seq_fsm.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_WAIT_A  = 2'd0,
    S_WAIT_B  = 2'd1,
    S_WAIT_OP = 2'd2,
    S_SHOW    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_SUB  = 3'd0,
    OP_ADD  = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  localparam int FLAG_P = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

endpackage

// File: rtl/alu_seq_fsm_core.sv
// Combinational ALU: (a, b, op) -> (r, flags {N,Z,C,V,P}).
// Ports: a, b [N], op [3] in; r [N], flags [5] out.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] r,
  output logic [4:0]   flags
);

  logic [N:0] sum;
  logic [N:0] diff;
  logic       c;
  logic       v;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit N of the extended difference is the borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (op_t'(op))
      OP_SUB: begin
        r = diff[N-1:0];
        c = diff[N];
        v = (a[N-1] != b[N-1]) &&
            (diff[N-1] != a[N-1]);
      end
      OP_ADD: begin
        r = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] == b[N-1]) &&
            (sum[N-1] != a[N-1]);
      end
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_SLL: begin
        r = {a[N-2:0], 1'b0};
        c = a[N-1];
      end
      OP_SRL: begin
        r = {1'b0, a[N-1:1]};
        c = a[0];
      end
      OP_PASS: r = a;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = r[N-1];
    flags[FLAG_Z] = (r == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
    flags[FLAG_P] = ^r;
  end

endmodule

// File: rtl/alu_seq_fsm.sv
// Sequential ALU: operands A, B and opcode entered one per enter pulse.
// Ports: clk, reset, clear, enter, data_in[N], op_in[3] in;
// display[N], result[N], flags[5], state[2], result_valid out.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic [2:0]   op_in,
  input  logic         enter,
  input  logic         clear,
  output logic [N-1:0] display,
  output logic [N-1:0] result,
  output logic [4:0]   flags,
  output logic [1:0]   state,
  output logic         result_valid
);

  state_t      st;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  logic [2:0]   op_reg;
  logic [2:0]   op_sel;
  logic [N-1:0] alu_r;
  logic [4:0]   alu_f;

  // Live opcode while it is being entered, else the held one.
  assign op_sel = (st == S_WAIT_OP) ? op_in : op_reg;

  alu_core #(.N(N)) u_core (
    .a     (a_reg),
    .b     (b_reg),
    .op    (op_sel),
    .r     (alu_r),
    .flags (alu_f)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      st           <= S_WAIT_A;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
    end else if (enter) begin
      unique case (st)
        S_WAIT_A: begin
          a_reg <= data_in;
          st    <= S_WAIT_B;
        end
        S_WAIT_B: begin
          b_reg <= data_in;
          st    <= S_WAIT_OP;
        end
        S_WAIT_OP: begin
          op_reg       <= op_in;
          result       <= alu_r;
          flags        <= alu_f;
          result_valid <= 1'b1;
          st           <= S_SHOW;
        end
        S_SHOW: begin
          a_reg        <= result;
          result_valid <= 1'b0;
          st           <= S_WAIT_B;
        end
      endcase
    end
  end

  assign state = st;

  always_comb begin
    display = data_in;
    unique case (st)
      S_WAIT_A:  display = data_in;
      S_WAIT_B:  display = data_in;
      S_WAIT_OP: display = N'(op_in);
      S_SHOW:    display = result;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Directed bench for alu_seq_fsm (N=8).
// Inputs driven on negedge, outputs sampled on the following negedge.
module tb_alu_seq_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic [2:0] op_in;
  logic       enter;
  logic       clear;
  logic [7:0] display;
  logic [7:0] result;
  logic [4:0] flags;
  logic [1:0] state;
  logic       result_valid;

  int n_run  = 0;
  int n_fail = 0;

  alu_seq_fsm #(.N(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .op_in        (op_in),
    .enter        (enter),
    .clear        (clear),
    .display      (display),
    .result       (result),
    .flags        (flags),
    .state        (state),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d,
                      input logic [2:0] o);
    @(negedge clk);
    data_in = d;
    op_in   = o;
    enter   = 1'b1;
    @(negedge clk);
    enter   = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run3(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [2:0] o);
    do_clear();
    push(a, 3'd0);
    push(b, 3'd0);
    push(8'h00, o);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    clear   = 1'b0;
    enter   = 1'b0;
    data_in = 8'h3c;
    op_in   = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_res", 32'(result), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("disp_live", 32'(display), 32'h3c);

    push(8'h7f, 3'd0);
    chk("st_b", 32'(state), 32'd1);
    push(8'h01, 3'd0);
    chk("st_op", 32'(state), 32'd2);
    op_in = 3'b101;
    #1;
    chk("disp_op", 32'(display), 32'h05);
    push(8'h00, 3'b001);
    chk("add_st", 32'(state), 32'd3);
    chk("add_res", 32'(result), 32'h80);
    chk("add_flg", 32'(flags), 32'b10011);
    chk("add_val", 32'(result_valid), 32'd1);
    chk("add_disp", 32'(display), 32'h80);

    push(8'h55, 3'd0);
    chk("chain_st", 32'(state), 32'd1);
    chk("chain_hold", 32'(result), 32'h80);
    chk("chain_val", 32'(result_valid), 32'd0);
    push(8'h80, 3'd0);
    push(8'h00, 3'b011);
    chk("and_res", 32'(result), 32'h80);
    chk("and_flg", 32'(flags), 32'b10001);

    run3(8'h05, 8'h05, 3'b000);
    chk("sub0_res", 32'(result), 32'h00);
    chk("sub0_flg", 32'(flags), 32'b01000);

    run3(8'h03, 8'h05, 3'b000);
    chk("subb_res", 32'(result), 32'hfe);
    chk("subb_flg", 32'(flags), 32'b10101);

    run3(8'h81, 8'h5a, 3'b101);
    chk("sll_res", 32'(result), 32'h02);
    chk("sll_flg", 32'(flags), 32'b00101);

    run3(8'hff, 8'h01, 3'b001);
    chk("wrap_res", 32'(result), 32'h00);
    chk("wrap_flg", 32'(flags), 32'b01100);

    run3(8'h01, 8'h00, 3'b110);
    chk("srl_res", 32'(result), 32'h00);
    chk("srl_flg", 32'(flags), 32'b01100);

    run3(8'h80, 8'h01, 3'b000);
    chk("subv_res", 32'(result), 32'h7f);
    chk("subv_flg", 32'(flags), 32'b00011);

    // clear beats enter in S_WAIT_OP
    run3(8'h81, 8'h00, 3'b101);
    push(8'h11, 3'd0);
    push(8'h22, 3'd0);
    @(negedge clk);
    op_in = 3'b001;
    enter = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    clear = 1'b0;
    chk("clr_st", 32'(state), 32'd0);
    chk("clr_res", 32'(result), 32'h0);
    chk("clr_flg", 32'(flags), 32'h0);
    chk("clr_val", 32'(result_valid), 32'd0);

    push(8'h0f, 3'd0);
    push(8'h01, 3'd0);
    push(8'h00, 3'b100);
    chk("xor_res", 32'(result), 32'h0e);
    chk("xor_flg", 32'(flags), 32'b00001);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
